sram_mem_controller: RTL

SRAM_MEM_CONTROLLER -- requirements
Module: sram_mem_controller

---
 rtl/sram_mem_controller_if.sv | 40 ++++
 rtl/sram_mem_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller_if.sv
// ---------------------------------------------------------------------------
// sram_mem_controller_if
//   Pipeline-side (MEM stage) bus for the 32-bit SRAM controller.
//
//   wr_en       store request
//   rd_en       load request
//   address     byte address of the 32-bit word (bits [1:0] ignored)
//   write_data  store data
//   read_data   load result
//   ready       access complete; the pipeline freezes while ready is low
//
//   master : pipeline side (drives requests)
//   slave  : controller side (drives read_data / ready)
// ---------------------------------------------------------------------------
interface sram_mem_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en,
    output rd_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//   Splits each 32-bit load/store from the MEM stage into two 16-bit SRAM
//   accesses (low half-word, then high half-word). Each phase lasts
//   WAIT_CYCLES+1 clocks. ready drops combinationally as soon as a request
//   is seen in IDLE and returns high for one cycle in DONE.
//
// Parameters
//   WAIT_CYCLES  extra wait cycles per 16-bit phase (0..7)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          pipeline-side bus (slave modport)
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_oe   drive enable for the SRAM data bus
//   sram_dq_in   SRAM read data
//   sram_we_n    SRAM write strobe, active-low
//
// States
//   IDLE | waiting for a request; ready=1 unless a request is present
//   LOW  | low half-word access  (sram_addr LSB = 0)
//   HIGH | high half-word access (sram_addr LSB = 1)
//   DONE | ready=1 for one cycle, then back to IDLE
// ---------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus,
  output logic [17:0]           sram_addr,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_we_n
);

  localparam logic [2:0] WAIT_TC = WAIT_CYCLES[2:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  cnt;
  logic        op_wr;
  logic [16:0] lat_addr;
  logic [31:0] lat_data;
  logic [31:0] rd_data;

  logic        start;
  logic        cnt_clr;
  logic        in_phase;
  logic        phase_last;
  logic        cap_lo;
  logic        cap_hi;

  // Address bits outside the 512 KiB window and the byte offset are unused.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[31:19], bus.address[1:0]};

  assign phase_last    = (cnt == WAIT_TC);
  assign bus.read_data = rd_data;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    cnt_clr     = 1'b0;
    in_phase    = 1'b0;
    cap_lo      = 1'b0;
    cap_hi      = 1'b0;
    bus.ready   = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.wr_en || bus.rd_en) begin
          bus.ready = 1'b0;
          start     = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = LOW;
        end
      end

      LOW: begin
        in_phase  = 1'b1;
        sram_addr = {lat_addr, 1'b0};
        if (op_wr) begin
          sram_dq_out = lat_data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (phase_last) begin
          cap_lo    = ~op_wr;
          cnt_clr   = 1'b1;
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        in_phase  = 1'b1;
        sram_addr = {lat_addr, 1'b1};
        if (op_wr) begin
          sram_dq_out = lat_data[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (phase_last) begin
          cap_hi    = ~op_wr;
          cnt_clr   = 1'b1;
          state_nxt = DONE;
        end
      end

      DONE: begin
        bus.ready = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset overrides the strobes immediately so an aborted write cannot
    // land on the SRAM at the reset edge.
    if (rst) begin
      bus.ready   = 1'b1;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_addr   = 18'd0;
      sram_dq_out = 16'd0;
      start       = 1'b0;
      cap_lo      = 1'b0;
      cap_hi      = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Phase counter, request latch and read-data capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      op_wr    <= 1'b0;
      lat_addr <= 17'd0;
      lat_data <= 32'd0;
      rd_data  <= 32'd0;
    end else begin
      if (cnt_clr) begin
        cnt <= 3'd0;
      end else if (in_phase) begin
        cnt <= cnt + 3'd1;
      end

      if (start) begin
        // A simultaneous read+write is treated as a write.
        op_wr    <= bus.wr_en;
        lat_addr <= bus.address[18:2];
        lat_data <= bus.write_data;
      end

      if (cap_lo) begin
        rd_data[15:0] <= sram_dq_in;
      end
      if (cap_hi) begin
        rd_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule
